unified_mem: RTL and testbench
==============================

# unified_mem

Parametrised unified memory subsystem placed between the core and its storage. It replaces the separate instruction-fetch and data views of RAM with one shared synchronous array. An instruction-fetch port and a data port reach that array through a request/grant arbiter with a starvation guard, byte-enabled writes, range/alignment error responses, and a configurable fixed read latency.

## Interface
- DATA_W, 32: word width in bits; must be a multiple of 8.
- DEPTH, 10240: number of words in the array.
- ADDR_W, 32: byte-address width on both ports.
- LATENCY, 1: cycles from acceptance to response; legal range 1..4.
- STARVE_MAX, 3: consecutive fetch losses after which fetch is granted regardless of priority.
- INIT_FILE, "": hex image loaded into the array at elaboration; empty string means no load.
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request.
- if_addr  in  ADDR_W  fetch byte address.
- if_gnt  out  1  fetch request accepted this cycle (combinational).
- if_rvalid  out  1  fetch response valid (registered).
- if_rdata  out  DATA_W  fetch read data.
- if_err  out  1  fetch response is an error.
- d_req  in  1  data request.
- d_we  in  1  1 = write, 0 = read.
- d_be  in  DATA_W/8  write byte enables.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  DATA_W  write data.
- d_gnt  out  1  data request accepted this cycle (combinational).
- d_rvalid  out  1  data response valid (registered).
- d_rdata  out  DATA_W  data read data.
- d_err  out  1  data response is an error.

## Operation
- Word index = addr >> log2(DATA_W/8).
- Error when low address bits are nonzero (misaligned), or when word index >= DEPTH. An errored access performs no write and returns rdata 0 with err = 1.
- Arbitration allows at most one grant per cycle:
  - Data wins a same-cycle conflict, unless starve_cnt == STARVE_MAX; then fetch wins.
  - A lone requester is always granted.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) each cycle fetch requests and loses.
  - Clears on any fetch grant and on any cycle with if_req low.
- Accepted = req & gnt at a rising edge.
- Accepted read: the array is read at the acceptance edge.
- Accepted write: bytes with d_be[i] = 1 are updated at the acceptance edge; other bytes are unchanged. d_be = 0 is a legal no-op write.
- Every accepted access, read or write, produces exactly one response on its own port. A write response carries rdata 0 and err as computed.
- Responses travel through a LATENCY-stage pipeline of {valid, port, err, data}. Order is preserved per port and globally.
- A read accepted the cycle after a write to the same word returns the new data. There is no same-cycle hazard, since only one access is accepted per cycle.
- Requesters hold req/addr/data stable until gnt. Inputs are sampled only at the grant edge.
- Reset (reset = 0), asynchronous:
  - Clears all pipeline valids, starve_cnt, rvalid/err/rdata outputs to 0.
  - In-flight responses are dropped.
  - Array contents are retained; no write occurs while reset is low.
  - gnt outputs are 0 while reset is low.

## Timing
- Grant is combinational from req, priority and starve_cnt in the same cycle.
- Acceptance at edge N: rvalid is high for exactly one cycle, beginning after edge N+LATENCY-1. For LATENCY = 1 this is the cycle immediately after acceptance.
- Throughput: one accepted access per cycle total. Back-to-back grants give back-to-back responses.
- After reset deassertion, the first grant is possible in the same cycle. The first response comes LATENCY edges after that grant.
- All outputs except gnt are registered. rdata/err are 0 whenever rvalid is 0.

## Test plan
- LATENCY = 1: write 0xDEADBEEF to 0x40 with be = 0xF, then read 0x40 next cycle. Response: d_rvalid one cycle after each grant; read returns 0xDEADBEEF, err = 0.
- Byte enables: word 0x40 = 0xDEADBEEF, write 0x11223344 with be = 0b0101, read back. Expected 0xDE22BE44.
- Errors: read at 0x42, and read at byte address 4*DEPTH. Both respond with err = 1, rdata 0. A write to 4*DEPTH leaves word DEPTH-1 unchanged.
- Contention with STARVE_MAX = 3: both ports request continuously. Grant pattern D,D,D,F repeats; every grant yields exactly one response on the correct port, in order.
- LATENCY = 3: reads on consecutive cycles to 0x0, 0x4, 0x8. rvalid is high on 3 consecutive cycles starting 3 edges after the first grant, with correct data in order.
- Reset mid-flight, LATENCY = 3: pull reset low one cycle after a grant. Outputs go to 0 immediately and no response appears after release; a previously written word reads back unchanged.

Source files
------------

// File: rtl/unified_mem.sv
`default_nettype none
// ============================================================================
// Module   : unified_mem
// Purpose  : Shared synchronous word array behind an instruction-fetch port
//            and a data port. The ports are arbitrated one access per cycle
//            with data priority and a starvation guard for fetch. Writes are
//            byte-enabled, bad addresses get error responses, and read
//            latency is fixed and configurable.
// Revision : 1.0 - initial release
// ============================================================================
module unified_mem #(
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 10240,
  parameter int ADDR_W     = 32,
  parameter int LATENCY    = 1,
  parameter int STARVE_MAX = 3,
  parameter     INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_W-1:0]     if_rdata,
  output logic                  if_err,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [DATA_W/8-1:0]   d_be,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  d_err
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW    = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  // One in-flight response: port 0 = fetch, 1 = data
  typedef struct packed {
    logic              valid;
    logic              port;
    logic              err;
    logic [DATA_W-1:0] data;
  } resp_t;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [SW-1:0]     starve_cnt;
  logic              starved;
  logic              acc;
  logic              acc_write;
  logic              acc_err;
  logic [ADDR_W-1:0] sel_addr;
  logic [ADDR_W-1:0] sel_word;
  logic [IDX_W-1:0]  idx;
  resp_t             stage_in;
  resp_t             tail;

  assign starved = (starve_cnt == SW'(STARVE_MAX));

  // Grant: data wins conflicts unless fetch has lost too often; nothing in reset
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (reset) begin
      if (d_req && !(if_req && starved)) d_gnt = 1'b1;
      else if (if_req)                   if_gnt = 1'b1;
    end
  end

  // Decode the granted access and form the response entering the pipeline
  always_comb begin
    acc       = if_gnt | d_gnt;
    acc_write = d_gnt & d_we;
    sel_addr  = if_gnt ? if_addr : d_addr;
    sel_word  = sel_addr >> OFF_W;
    idx       = sel_word[IDX_W-1:0];
    acc_err   = ((sel_addr & ADDR_W'(BYTES - 1)) != '0) ||
                (sel_word >= ADDR_W'(DEPTH));
    stage_in       = '0;
    stage_in.valid = acc;
    stage_in.port  = d_gnt;
    stage_in.err   = acc & acc_err;
    if (acc && !acc_err && !acc_write) stage_in.data = mem[idx];
  end

  // Count consecutive fetch losses, saturating at the guard threshold
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  starve_cnt <= '0;
    else if (!if_req || if_gnt)  starve_cnt <= '0;
    else if (!starved)           starve_cnt <= starve_cnt + 1'b1;
  end

  // Byte-enabled array write; errored writes are suppressed
  always_ff @(posedge clk) begin
    if (acc_write && !acc_err) begin
      for (int b = 0; b < BYTES; b++) begin
        if (d_be[b]) mem[idx][b*8 +: 8] <= d_wdata[b*8 +: 8];
      end
    end
  end

  // Delay line of LATENCY-1 stages; the output registers form the last stage
  generate
    if (LATENCY <= 1) begin : g_direct
      assign tail = stage_in;
    end else begin : g_pipe
      resp_t pipe [LATENCY-1];
      // Shift responses toward the output registers
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int s = 0; s < LATENCY - 1; s++) pipe[s] <= '0;
        end else begin
          pipe[0] <= stage_in;
          for (int s = 1; s < LATENCY - 1; s++) pipe[s] <= pipe[s-1];
        end
      end
      assign tail = pipe[LATENCY-2];
    end
  endgenerate

  // Route the final stage to its port; data and err are zero when not valid
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_rvalid <= 1'b0;
      if_err    <= 1'b0;
      if_rdata  <= '0;
      d_rvalid  <= 1'b0;
      d_err     <= 1'b0;
      d_rdata   <= '0;
    end else begin
      if_rvalid <= tail.valid & ~tail.port;
      if_err    <= tail.valid & ~tail.port & tail.err;
      if_rdata  <= (tail.valid && !tail.port) ? tail.data : '0;
      d_rvalid  <= tail.valid & tail.port;
      d_err     <= tail.valid & tail.port & tail.err;
      d_rdata   <= (tail.valid && tail.port) ? tail.data : '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_unified_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_unified_mem
// Purpose  : Bench for unified_mem. Two instances (latency 1 and 3) receive
//            identical stimulus and are compared against a reference model
//            holding the array contents and a history of expected responses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_unified_mem;

  localparam int DEPTH = 256;
  localparam int SMAX  = 3;

  typedef struct packed {
    logic        port;
    logic        err;
    logic [31:0] data;
  } resp_t;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;

  logic        if_gnt_o    [2];
  logic        if_rvalid_o [2];
  logic [31:0] if_rdata_o  [2];
  logic        if_err_o    [2];
  logic        d_gnt_o     [2];
  logic        d_rvalid_o  [2];
  logic [31:0] d_rdata_o   [2];
  logic        d_err_o     [2];

  unified_mem #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32), .LATENCY(1), .STARVE_MAX(SMAX)) u_lat1 (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_o[0]),
    .if_rvalid(if_rvalid_o[0]), .if_rdata(if_rdata_o[0]), .if_err(if_err_o[0]),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt_o[0]), .d_rvalid(d_rvalid_o[0]), .d_rdata(d_rdata_o[0]), .d_err(d_err_o[0])
  );

  unified_mem #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32), .LATENCY(3), .STARVE_MAX(SMAX)) u_lat3 (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_o[1]),
    .if_rvalid(if_rvalid_o[1]), .if_rdata(if_rdata_o[1]), .if_err(if_err_o[1]),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt_o[1]), .d_rvalid(d_rvalid_o[1]), .d_rdata(d_rdata_o[1]), .d_err(d_err_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] mem_m [DEPTH];
  resp_t       hist [int];     // expected response keyed by acceptance edge
  int          starve;
  int          edge_n;
  int          tests;
  int          fails;
  logic        exp_ifg;
  logic        exp_dg;
  logic        obs_ifg;

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: predict grants, check both DUTs, then advance the model
  task automatic step();
    int          k;
    logic [33:0] exp_if;
    logic [33:0] exp_d;
    logic [31:0] a;
    resp_t       r;
    if (!reset) begin
      hist.delete();
      starve = 0;
    end
    exp_ifg = 1'b0;
    exp_dg  = 1'b0;
    if (reset) begin
      if (d_req && !(if_req && starve == SMAX)) exp_dg = 1'b1;
      else if (if_req)                          exp_ifg = 1'b1;
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("lat%0d.if_gnt", lat_of(d)), 34'(if_gnt_o[d]), 34'(exp_ifg));
      chk($sformatf("lat%0d.d_gnt", lat_of(d)), 34'(d_gnt_o[d]), 34'(exp_dg));
      k = edge_n - lat_of(d) + 1;
      exp_if = '0;
      exp_d  = '0;
      if (hist.exists(k)) begin
        if (hist[k].port) exp_d  = {1'b1, hist[k].err, hist[k].data};
        else              exp_if = {1'b1, hist[k].err, hist[k].data};
      end
      chk($sformatf("lat%0d.if_resp@%0d", lat_of(d), edge_n),
          {if_rvalid_o[d], if_err_o[d], if_rdata_o[d]}, exp_if);
      chk($sformatf("lat%0d.d_resp@%0d", lat_of(d), edge_n),
          {d_rvalid_o[d], d_err_o[d], d_rdata_o[d]}, exp_d);
    end
    obs_ifg = if_gnt_o[0];
    @(posedge clk);
    edge_n++;
    if (reset && (exp_ifg || exp_dg)) begin
      a      = exp_ifg ? if_addr : d_addr;
      r.port = exp_dg;
      r.err  = (a[1:0] != 2'b00) || ((a >> 2) >= DEPTH);
      r.data = '0;
      if (!r.err) begin
        if (exp_dg && d_we) begin
          for (int b = 0; b < 4; b++)
            if (d_be[b]) mem_m[a[9:2]][8*b +: 8] = d_wdata[8*b +: 8];
        end else begin
          r.data = mem_m[a[9:2]];
        end
      end
      hist[edge_n] = r;
    end
    if (reset) begin
      if (!if_req || exp_ifg) starve = 0;
      else if (starve < SMAX) starve++;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    if_req = 1'b0;
    d_req  = 1'b0;
    step();
  endtask

  task automatic dwrite(input logic [31:0] a, input logic [31:0] w, input logic [3:0] be);
    if_req = 1'b0; d_req = 1'b1; d_we = 1'b1; d_addr = a; d_wdata = w; d_be = be;
    step();
    d_req = 1'b0;
  endtask

  task automatic dread(input logic [31:0] a);
    if_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = a; d_be = 4'h0;
    step();
    d_req = 1'b0;
  endtask

  task automatic fread(input logic [31:0] a);
    d_req = 1'b0; if_req = 1'b1; if_addr = a;
    step();
    if_req = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 19);
    if (r == 0)      return (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
    else if (r == 1) return 32'(DEPTH + $urandom_range(0, 1000)) << 2;
    else             return 32'($urandom_range(0, DEPTH - 1)) << 2;
  endfunction

  initial begin
    logic [7:0] pat;
    logic       pend_if;
    logic       pend_d;
    tests = 0; fails = 0; starve = 0; edge_n = 0;
    if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_be = '0; d_addr = '0; d_wdata = '0;
    reset = 1'b1;
    #2 reset = 1'b0;
    @(negedge clk);
    // Reset state, with a request pending that must not be granted
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0; d_wdata = 32'h1234_5678; d_be = 4'hF;
    step();
    step();
    d_req = 1'b0;
    reset = 1'b1;

    // Fill the whole array so every later read is defined
    for (int w = 0; w < DEPTH; w++) dwrite(32'(w) << 2, $urandom, 4'hF);

    // Full write then read-after-write
    dwrite(32'h40, 32'hDEAD_BEEF, 4'hF);
    dread(32'h40);
    chk("raw_full_lat1", {d_rvalid_o[0], d_err_o[0], d_rdata_o[0]}, {2'b10, 32'hDEAD_BEEF});

    // Partial byte-enable write
    dwrite(32'h40, 32'h1122_3344, 4'b0101);
    dread(32'h40);
    chk("byte_en_lat1", {d_rvalid_o[0], d_err_o[0], d_rdata_o[0]}, {2'b10, 32'hDE22_BE44});

    // Error responses: misaligned, out of range, and out-of-range write
    dread(32'h42);
    chk("misaligned_lat1", {d_rvalid_o[0], d_err_o[0], d_rdata_o[0]}, {2'b11, 32'h0});
    dread(32'(DEPTH) << 2);
    chk("out_of_range_lat1", {d_rvalid_o[0], d_err_o[0], d_rdata_o[0]}, {2'b11, 32'h0});
    dwrite(32'(DEPTH) << 2, 32'hFFFF_FFFF, 4'hF);
    dread(32'(DEPTH - 1) << 2);

    // Fetch port read of the same word
    fread(32'h40);
    chk("fetch_lat1", {if_rvalid_o[0], if_err_o[0], if_rdata_o[0]}, {2'b10, 32'hDE22_BE44});

    // Continuous contention: D,D,D,F repeating
    idle();
    if_req = 1'b1; if_addr = 32'h40;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44;
    for (int i = 0; i < 8; i++) begin
      step();
      pat[i] = obs_ifg;
    end
    chk("grant_pattern", 34'(pat), 34'(8'b1000_1000));
    for (int i = 0; i < 4; i++) idle();

    // Back-to-back reads through the latency-3 instance
    dread(32'h0);
    dread(32'h4);
    dread(32'h8);
    chk("lat3_burst0", {d_rvalid_o[1], d_err_o[1], d_rdata_o[1]}, {2'b10, mem_m[0]});
    idle();
    chk("lat3_burst1", {d_rvalid_o[1], d_err_o[1], d_rdata_o[1]}, {2'b10, mem_m[1]});
    idle();
    chk("lat3_burst2", {d_rvalid_o[1], d_err_o[1], d_rdata_o[1]}, {2'b10, mem_m[2]});
    idle();

    // Reset one cycle after a grant: in-flight response dropped, array kept
    dwrite(32'h80, 32'hCAFE_F00D, 4'hF);
    dread(32'h80);
    reset = 1'b0;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'h0; d_be = 4'hF;
    step();
    chk("reset_flush_lat3", {d_rvalid_o[1], d_err_o[1], d_rdata_o[1]}, 34'h0);
    step();
    reset = 1'b1;
    d_req = 1'b0;
    for (int i = 0; i < 4; i++) idle();
    dread(32'h80);
    chk("retained_lat1", {d_rvalid_o[0], d_err_o[0], d_rdata_o[0]}, {2'b10, 32'hCAFE_F00D});
    for (int i = 0; i < 3; i++) idle();

    // Randomised traffic; requesters hold their request until granted
    pend_if = 1'b0;
    pend_d  = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (!pend_if) begin
        if_req  = ($urandom_range(0, 2) != 0);
        if_addr = rand_addr();
      end
      if (!pend_d) begin
        d_req   = ($urandom_range(0, 2) != 0);
        d_we    = $urandom_range(0, 1) == 1;
        d_be    = 4'($urandom_range(0, 15));
        d_addr  = rand_addr();
        d_wdata = $urandom;
      end
      step();
      pend_if = if_req && !exp_ifg;
      pend_d  = d_req && !exp_dg;
    end
    for (int i = 0; i < 4; i++) idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
